// File: rtl/pc_redirect_pkg.sv
// Shared types for the fetch-PC redirect block: branch type encoding, FSM states,
// the sequential fetch step and small helpers for taken/alignment decisions.
package pc_redirect_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BR_BEQ  = 2'b00,
    BR_BNE  = 2'b01,
    BR_JMP  = 2'b10,
    BR_RSVD = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_F1  = 2'b01,
    ST_F2  = 2'b10
  } state_e;

  // Reserved encoding never redirects.
  function automatic logic branch_taken(input logic valid, input br_type_e t, input logic eq);
    logic tk;
    tk = 1'b0;
    case (t)
      BR_BEQ:  tk = eq;
      BR_BNE:  tk = ~eq;
      BR_JMP:  tk = 1'b1;
      default: tk = 1'b0;
    endcase
    return valid & tk;
  endfunction

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_sat_cnt.sv
// Saturating event counter with asynchronous clear; sticks at all-ones.
module pc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC sequencer with one-cycle branch redirect and two-cycle IF/ID flush window.
// Optional branch statistics counters are built only when PC_PERF_CNT_EN is defined.
module pc_redirect
  import pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BR_VALID,
  input  logic [1:0]  BR_TYPE,
  input  logic        BR_EQ,
  input  logic [31:0] BR_TARGET,
  output logic [31:0] PC,
  output logic        FLUSH,
  output logic        MISALIGN,
  output logic [15:0] BR_CNT,
  output logic [15:0] TAKEN_CNT,
  output state_e      STATE_DBG
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic        taken;
  logic        tgt_aligned;

  // Branch outcome only matters in RUN; in F1/F2 the EX instruction is wrong-path.
  assign taken       = (state_q == ST_RUN) &&
                       branch_taken(BR_VALID, br_type_e'(BR_TYPE), BR_EQ);
  assign tgt_aligned = is_word_aligned(BR_TARGET);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (taken) begin
          pc_d       = tgt_aligned ? BR_TARGET : TRAP_VEC;
          misalign_d = ~tgt_aligned;
          state_d    = ST_F1;
        end else if (!STALL) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_F1: begin
        if (!STALL) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_F2;
        end
      end
      ST_F2: begin
        if (!STALL) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    flush_d = (state_d != ST_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign PC        = pc_q;
  assign FLUSH     = flush_q;
  assign MISALIGN  = misalign_q;
  assign STATE_DBG = state_q;

`ifdef PC_PERF_CNT_EN
  logic br_inc;
  assign br_inc = (state_q == ST_RUN) && BR_VALID;

  pc_sat_cnt #(.W(16)) u_br_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (br_inc),
    .cnt_o (BR_CNT)
  );

  pc_sat_cnt #(.W(16)) u_taken_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (taken),
    .cnt_o (TAKEN_CNT)
  );
`else
  assign BR_CNT    = 16'h0000;
  assign TAKEN_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_redirect.sv
// Bench for pc_redirect: directed vector table, hand-written reset/counter sequences,
// then randomized traffic against a flush-countdown reference model.
module tb_pc_redirect;
  import pc_redirect_pkg::*;

`ifdef PC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] TRAP = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_type = 2'b00;
  logic        br_eq = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] pc;
  logic        flush, misalign;
  logic [15:0] br_cnt, taken_cnt;
  state_e      dbg_state;

  always #5 clk = ~clk;

  pc_redirect dut (
    .CLK(clk), .RST(rst), .STALL(stall), .BR_VALID(br_valid), .BR_TYPE(br_type),
    .BR_EQ(br_eq), .BR_TARGET(br_target), .PC(pc), .FLUSH(flush), .MISALIGN(misalign),
    .BR_CNT(br_cnt), .TAKEN_CNT(taken_cnt), .STATE_DBG(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic v, input logic [1:0] t,
                       input logic e, input logic [31:0] tg);
    stall = s; br_valid = v; br_type = t; br_eq = e; br_target = tg;
  endtask

  // Inputs change on negedge; outputs are sampled 1ns after the following posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        s, v;
    logic [1:0]  t;
    logic        e;
    logic [31:0] tg;
    logic [31:0] pc;
    logic        fl, mis;
  } vec_t;

  vec_t vt[20];

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  int          m_left;
  logic        m_mis;
  int          m_br, m_tk;

  task automatic model_reset();
    m_pc = 32'h0; m_left = 0; m_mis = 1'b0; m_br = 0; m_tk = 0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [1:0] t,
                            input logic e, input logic [31:0] tg);
    bit tk;
    m_mis = 1'b0;
    if (m_left == 0) begin
      tk = v && ((t == 2'd0 && e) || (t == 2'd1 && !e) || (t == 2'd2));
      if (v && m_br < 65535) m_br++;
      if (tk && m_tk < 65535) m_tk++;
      if (tk) begin
        if (tg % 4 == 0) m_pc = tg;
        else begin m_pc = TRAP; m_mis = 1'b1; end
        m_left = 2;
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
      m_left--;
    end
  endtask

  initial begin
    // Directed table, starting from PC=0 in RUN right after reset release.
    vt[0]  = '{0, 0, 2'd0, 0, 32'h0,        32'h4,        0, 0};
    vt[1]  = '{0, 0, 2'd0, 0, 32'h0,        32'h8,        0, 0};
    vt[2]  = '{0, 0, 2'd0, 0, 32'h0,        32'hC,        0, 0};
    vt[3]  = '{0, 1, 2'd0, 1, 32'h40,       32'h40,       1, 0};
    vt[4]  = '{0, 0, 2'd0, 0, 32'h0,        32'h44,       1, 0};
    vt[5]  = '{0, 0, 2'd0, 0, 32'h0,        32'h48,       0, 0};
    vt[6]  = '{0, 1, 2'd1, 1, 32'h80,       32'h4C,       0, 0};
    vt[7]  = '{0, 1, 2'd2, 0, 32'h200,      32'h200,      1, 0};
    vt[8]  = '{0, 1, 2'd2, 0, 32'h300,      32'h204,      1, 0};
    vt[9]  = '{1, 0, 2'd0, 0, 32'h0,        32'h204,      1, 0};
    vt[10] = '{1, 0, 2'd0, 0, 32'h0,        32'h204,      1, 0};
    vt[11] = '{0, 0, 2'd0, 0, 32'h0,        32'h208,      0, 0};
    vt[12] = '{1, 1, 2'd0, 0, 32'h600,      32'h208,      0, 0};
    vt[13] = '{1, 1, 2'd2, 0, 32'h42,       32'h100,      1, 1};
    vt[14] = '{0, 0, 2'd0, 0, 32'h0,        32'h104,      1, 0};
    vt[15] = '{0, 0, 2'd0, 0, 32'h0,        32'h108,      0, 0};
    vt[16] = '{0, 1, 2'd3, 1, 32'h500,      32'h10C,      0, 0};
    vt[17] = '{0, 1, 2'd1, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0};
    vt[18] = '{0, 0, 2'd0, 0, 32'h0,        32'h0,        1, 0};
    vt[19] = '{0, 0, 2'd0, 0, 32'h0,        32'h4,        0, 0};

    // Asynchronous reset visible without any clock edge.
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_flush", {31'b0, flush}, 32'h0);
    check("reset_mis", {31'b0, misalign}, 32'h0);
    check("reset_br_cnt", {16'b0, br_cnt}, 32'h0);
    check("reset_tk_cnt", {16'b0, taken_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].s, vt[i].v, vt[i].t, vt[i].e, vt[i].tg);
      step();
      check($sformatf("vec%0d_pc", i), pc, vt[i].pc);
      check($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vt[i].fl});
      check($sformatf("vec%0d_mis", i), {31'b0, misalign}, {31'b0, vt[i].mis});
      check($sformatf("vec%0d_state_flush", i), {31'b0, dbg_state != ST_RUN},
            {31'b0, vt[i].fl});
      @(negedge clk);
    end
    // RUN-evaluated branches in table: 7, of which taken: 4.
    check("tbl_br_cnt", {16'b0, br_cnt}, PERF ? 32'd7 : 32'd0);
    check("tbl_tk_cnt", {16'b0, taken_cnt}, PERF ? 32'd4 : 32'd0);

    // Reset asserted while in F1 takes effect immediately.
    drive(0, 1, 2'd2, 0, 32'h800);
    step();
    check("midf1_pre_flush", {31'b0, flush}, 32'h1);
    @(negedge clk);
    drive(0, 0, 2'd0, 0, 32'h0);
    #1 rst = 1'b1;
    #1;
    check("midf1_rst_pc", pc, 32'h0);
    check("midf1_rst_flush", {31'b0, flush}, 32'h0);
    check("midf1_rst_br_cnt", {16'b0, br_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("first_inc_pc", pc, 32'h4);
    @(negedge clk);

    // Three branches, two taken.
    drive(0, 1, 2'd0, 1, 32'h40); step(); @(negedge clk);
    drive(0, 0, 2'd0, 0, 32'h0);  step(); @(negedge clk);
    step(); @(negedge clk);
    drive(0, 1, 2'd1, 1, 32'h80); step(); @(negedge clk);
    drive(0, 1, 2'd2, 0, 32'h90); step();
    check("cnt3_pc", pc, 32'h90);
    @(negedge clk);
    drive(0, 0, 2'd0, 0, 32'h0);
    step();
    check("cnt3_br_cnt", {16'b0, br_cnt}, PERF ? 32'd3 : 32'd0);
    check("cnt3_tk_cnt", {16'b0, taken_cnt}, PERF ? 32'd2 : 32'd0);
    @(negedge clk);

    // Randomized traffic against the model.
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic        s, v, e;
      logic [1:0]  t;
      logic [31:0] tg;
      s  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 2) != 0);
      t  = 2'($urandom_range(0, 3));
      e  = 1'($urandom_range(0, 1));
      tg = $urandom;
      if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
      drive(s, v, t, e, tg);
      model_step(s, v, t, e, tg);
      step();
      check($sformatf("rnd%0d_pc", c), pc, m_pc);
      check($sformatf("rnd%0d_flush", c), {31'b0, flush}, {31'b0, m_left != 0});
      check($sformatf("rnd%0d_mis", c), {31'b0, misalign}, {31'b0, m_mis});
      check($sformatf("rnd%0d_br_cnt", c), {16'b0, br_cnt}, PERF ? 32'(m_br) : 32'd0);
      check($sformatf("rnd%0d_tk_cnt", c), {16'b0, taken_cnt}, PERF ? 32'(m_tk) : 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter TRAP_VEC, default 32'h00000100, PC loaded on misaligned branch target.
REQ-003 Reset is asynchronous and active-high: port RST; one clock, port CLK.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 STALL  input  1  holds fetch: PC and FSM hold when no redirect is pending.
REQ-007 BR_VALID  input  1  branch or jump instruction present in EX this cycle.
REQ-008 BR_TYPE  input  2  00 BEQ, 01 BNE, 10 JMP (unconditional), 11 reserved.
REQ-009 BR_EQ  input  1  equality result from branch comparator (1 = operands equal).
REQ-010 BR_TARGET  input  32  resolved target address.
REQ-011 PC  output  32  current fetch address, registered.
REQ-012 FLUSH  output  1  squash IF/ID wrong-path instructions, registered.
REQ-013 MISALIGN  output  1  one-cycle pulse, registered: redirect went to TRAP_VEC.
REQ-014 BR_CNT  output  16  resolved-branch count (see Configuration).
REQ-015 TAKEN_CNT  output  16  taken-branch count (see Configuration).

Function
REQ-016 TAKEN SHALL be BR_VALID & ((BEQ & BR_EQ) | (BNE & ~BR_EQ) | JMP); reserved type SHALL be not-taken.
REQ-017 FSM states: RUN, F1, F2; TAKEN SHALL only be evaluated in RUN.
REQ-018 RUN, TAKEN=1: next PC = BR_TARGET if BR_TARGET[1:0]==0, else TRAP_VEC with MISALIGN=1 next cycle; state -> F1; STALL ignored (redirect has priority).
REQ-019 RUN, TAKEN=0, STALL=0: PC <= PC + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-020 RUN, TAKEN=0, STALL=1: PC and state hold.
REQ-021 FLUSH SHALL be 1 exactly while state is F1 or F2; redirect latency is 1 cycle (branch in EX at cycle N -> PC=target and FLUSH=1 at N+1).
REQ-022 In F1/F2, BR_VALID SHALL be ignored (wrong-path instruction in EX); STALL=0: PC += 4 and F1->F2, F2->RUN; STALL=1: PC and state hold, FLUSH stays 1.
REQ-023 MISALIGN SHALL be 0 in every cycle not directly following a misaligned redirect.

Reset
REQ-024 RST=1 SHALL immediately force PC=RESET_PC, state=RUN, FLUSH=0, MISALIGN=0, BR_CNT=0, TAKEN_CNT=0, regardless of state, including mid-flush.
REQ-025 First PC increment SHALL occur on the first rising CLK edge after RST deasserts with STALL=0.

Configuration
REQ-026 Macro PC_PERF_CNT_EN: when defined, BR_CNT increments on each BR_VALID evaluated in RUN and TAKEN_CNT on each TAKEN, both saturating at 16'hFFFF.
REQ-027 Without PC_PERF_CNT_EN, BR_CNT and TAKEN_CNT ports SHALL exist and be constant 0; no counter flops synthesized.

Structure
REQ-028 Package pc_redirect_pkg SHALL hold the BR_TYPE encoding enum, the FSM state enum and constant PC_STEP=4.
REQ-029 Sub-module pc_sat_cnt (16-bit saturating counter, clear on RST, increment enable) SHALL be instantiated twice under PC_PERF_CNT_EN.

Verification
REQ-030 Reset release, STALL=0, BR_VALID=0 for 3 cycles -> PC 0, 4, 8, 12; FLUSH=0.
REQ-031 BEQ, BR_EQ=1, BR_TARGET=32'h00000040 at cycle N -> PC=0x40, FLUSH=1 at N+1 and N+2, PC=0x44, 0x48; BNE with BR_EQ=1 -> no redirect.
REQ-032 BR_VALID=1 JMP during F1 -> ignored, PC continues target+4; STALL=1 in F2 for 2 cycles -> PC and FLUSH=1 hold.
REQ-033 JMP, BR_TARGET=32'h00000042 -> PC=0x100, MISALIGN=1 for one cycle; PC=32'hFFFFFFFC, no branch -> PC=0.
REQ-034 RST asserted mid-F1 -> PC=RESET_PC, FLUSH=0 without a clock edge; with PC_PERF_CNT_EN, 3 branches (2 taken) -> BR_CNT=3, TAKEN_CNT=2; without macro both 0.
